hpdcache_sram_sweep: RTL and testbench
======================================

# hpdcache_sram_sweep

Initiator-side engine for a single-port HPDcache SRAM macro port (cs/we/addr/wdata/rdata, 1-cycle read latency). On request it sweeps every SRAM word and writes INIT_VALUE; optionally it reads every word back and flags mismatches. When idle it passes a functional request port straight through to the SRAM. It sits between cache controller logic (directory, data, MSHR arrays) and each SRAM instance, because the SRAM wrapper does not initialize contents.

## Interface
- ADDR_SIZE, 6, SRAM address width
- DATA_SIZE, 64, SRAM word width
- DEPTH, 2**ADDR_SIZE, number of words swept (1..2**ADDR_SIZE)
- INIT_VALUE, '0, DATA_SIZE-bit value written to every word
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  reset, synchronous, active-low
- start_i  in  1  start sweep (sampled only in IDLE)
- busy_o  out  1  sweep in progress; functional port blocked
- done_o  out  1  one-cycle pulse at sweep end
- err_o  out  1  sticky readback mismatch
- err_addr_o  out  ADDR_SIZE  address of first mismatch
- req_cs_i, req_we_i  in  1  functional request
- req_addr_i  in  ADDR_SIZE  functional address
- req_wdata_i  in  DATA_SIZE  functional write data
- req_ready_o  out  1  functional port granted (= !busy_o)
- req_rdata_o  out  DATA_SIZE  = sram_rdata_i, unconditionally
- sram_cs_o, sram_we_o  out  1  to SRAM
- sram_addr_o  out  ADDR_SIZE  to SRAM
- sram_wdata_o  out  DATA_SIZE  to SRAM
- sram_rdata_i  in  DATA_SIZE  from SRAM, valid one cycle after cs&!we

## Operation
- States: IDLE, WRITE, READ, DRAIN, DONE. Address counter cnt (ADDR_SIZE bits).
- IDLE/DONE: sram_* = req_* combinationally; req_ready_o=1, busy_o=0.
- IDLE & start_i -> WRITE, cnt=0, err_o/err_addr_o cleared.
- WRITE: sram_cs_o=1, sram_we_o=1, sram_addr_o=cnt, sram_wdata_o=INIT_VALUE; cnt++ each cycle. cnt==DEPTH-1 -> READ (cnt=0) if check enabled, else DONE.
- READ: sram_cs_o=1, sram_we_o=0, sram_addr_o=cnt; cnt++. Address registered into compare stage. cnt==DEPTH-1 -> DRAIN.
- DRAIN: sram_cs_o=0; last readback compared. -> DONE.
- Compare: each cycle after a READ, sram_rdata_i != INIT_VALUE sets err_o; err_addr_o loads only on first mismatch of the sweep.
- DONE: done_o=1 for exactly that cycle; -> IDLE unconditionally.
- In WRITE/READ/DRAIN: busy_o=1, req_ready_o=0; req_cs_i ignored (caller must hold its request).
- start_i outside IDLE ignored (no queuing).
- Counter never exceeds DEPTH-1; non-power-of-two DEPTH never touches addresses >= DEPTH.

## Timing
- Reset (rst_n low at edge): state IDLE, cnt=0, busy_o=0, done_o=0, err_o=0, err_addr_o=0, req_ready_o=1; compare stage invalidated. Applies mid-sweep: sweep abandoned, no done_o pulse.
- start_i sampled at edge 0: first write at cycle 1, last write at cycle DEPTH.
- No check: done_o at cycle DEPTH+1. With check: reads cycles DEPTH+1..2*DEPTH, DRAIN 2*DEPTH+1, done_o 2*DEPTH+2.
- err_o valid no later than done_o cycle.
- start_i with req_cs_i in same IDLE cycle: functional access issued that cycle; sweep begins next cycle.
- Functional reads in IDLE: data on req_rdata_o next cycle, even if sweep then starts.

## Configuration
- HPDCACHE_SRAM_SWEEP_CHECK_EN defined: READ/DRAIN states and compare stage present; behaviour as above.
- Not defined: WRITE -> DONE directly; err_o and err_addr_o tied 0; no compare logic.

## Structure
- hpdcache_sram_sweep_pkg: state enum typedef (IDLE, WRITE, READ, DRAIN, DONE).
- Sub-module hpdcache_sram_sweep_checker (compare pipeline register, sticky error, first-address capture), instantiated only under HPDCACHE_SRAM_SWEEP_CHECK_EN.
- Top: FSM, counter, output mux.

## Test plan
- DEPTH=64, no check, start at cycle 0 -> 64 writes addr 0..63 data 0, done_o at cycle 65 only, busy_o high cycles 1..64.
- Check enabled, behavioural SRAM -> reads 0..63 cycles 65..128, done_o cycle 130, err_o=0.
- Check enabled, SRAM model forces addr 17 and 40 rdata=0x1 -> err_o=1 by done, err_addr_o=17; next start clears both.
- rst_n low at cycle 20 mid-WRITE -> IDLE next cycle, busy_o=0, no done_o; pass-through active.
- IDLE read addr 5 with start_i same cycle -> sram_addr_o=5 that cycle, req_rdata_o valid next cycle, sweep writes addr 0 next cycle; req_cs_i during busy produces no SRAM access.
- DEPTH=48, ADDR_SIZE=6 -> writes stop at 47, done_o at cycle 49; start_i pulsed while busy ignored.

Source files
------------

// File: rtl/hpdcache_sram_sweep_pkg.sv
// Shared types for the HPDcache SRAM init/readback sweep engine.
package hpdcache_sram_sweep_pkg;

  typedef enum logic [2:0] {
    SWEEP_IDLE  = 3'd0,
    SWEEP_WRITE = 3'd1,
    SWEEP_READ  = 3'd2,
    SWEEP_DRAIN = 3'd3,
    SWEEP_DONE  = 3'd4
  } sweep_state_e;

endpackage

// File: rtl/hpdcache_sram_sweep_if.sv
// SRAM macro port bundle: master = sweep engine, slave = SRAM macro.
interface hpdcache_sram_sweep_if #(
  parameter int unsigned ADDR_SIZE = 6,
  parameter int unsigned DATA_SIZE = 64
);
  logic                 sram_cs;
  logic                 sram_we;
  logic [ADDR_SIZE-1:0] sram_addr;
  logic [DATA_SIZE-1:0] sram_wdata;
  logic [DATA_SIZE-1:0] sram_rdata;

  modport master (output sram_cs, sram_we, sram_addr, sram_wdata, input sram_rdata);
  modport slave  (input sram_cs, sram_we, sram_addr, sram_wdata, output sram_rdata);
endinterface

// File: rtl/hpdcache_sram_sweep_checker.sv
// Readback compare stage: one-cycle address pipeline, sticky error, first-mismatch address.
// Present only when HPDCACHE_SRAM_SWEEP_CHECK_EN is defined.
`ifdef HPDCACHE_SRAM_SWEEP_CHECK_EN
module hpdcache_sram_sweep_checker #(
  parameter int unsigned          ADDR_SIZE  = 6,
  parameter int unsigned          DATA_SIZE  = 64,
  parameter logic [DATA_SIZE-1:0] INIT_VALUE = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr_i,
  input  logic                 rd_vld_i,
  input  logic [ADDR_SIZE-1:0] rd_addr_i,
  input  logic [DATA_SIZE-1:0] rdata_i,
  output logic                 err_o,
  output logic [ADDR_SIZE-1:0] err_addr_o
);
  logic                 cmp_vld_q, cmp_vld_d;
  logic [ADDR_SIZE-1:0] cmp_addr_q, cmp_addr_d;
  logic                 err_q, err_d;
  logic [ADDR_SIZE-1:0] err_addr_q, err_addr_d;

  always_comb begin
    cmp_vld_d  = rd_vld_i;
    cmp_addr_d = rd_addr_i;
    err_d      = err_q;
    err_addr_d = err_addr_q;
    if (clr_i) begin
      err_d      = 1'b0;
      err_addr_d = '0;
    end else if (cmp_vld_q && (rdata_i != INIT_VALUE)) begin
      err_d = 1'b1;
      if (!err_q) err_addr_d = cmp_addr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cmp_vld_q  <= 1'b0;
      cmp_addr_q <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      cmp_vld_q  <= cmp_vld_d;
      cmp_addr_q <= cmp_addr_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign err_o      = err_q;
  assign err_addr_o = err_addr_q;
endmodule
`endif

// File: rtl/hpdcache_sram_sweep.sv
// SRAM init sweep engine with functional pass-through when idle.
// Optional readback check enabled by defining HPDCACHE_SRAM_SWEEP_CHECK_EN.
module hpdcache_sram_sweep
  import hpdcache_sram_sweep_pkg::*;
#(
  parameter int unsigned          ADDR_SIZE  = 6,
  parameter int unsigned          DATA_SIZE  = 64,
  parameter int unsigned          DEPTH      = 2**ADDR_SIZE,
  parameter logic [DATA_SIZE-1:0] INIT_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [ADDR_SIZE-1:0]  err_addr_o,
  input  logic                  req_cs_i,
  input  logic                  req_we_i,
  input  logic [ADDR_SIZE-1:0]  req_addr_i,
  input  logic [DATA_SIZE-1:0]  req_wdata_i,
  output logic                  req_ready_o,
  output logic [DATA_SIZE-1:0]  req_rdata_o,
  hpdcache_sram_sweep_if.master sram
);
  localparam logic [2:0] ST_IDLE  = SWEEP_IDLE;
  localparam logic [2:0] ST_WRITE = SWEEP_WRITE;
  localparam logic [2:0] ST_READ  = SWEEP_READ;
  localparam logic [2:0] ST_DRAIN = SWEEP_DRAIN;
  localparam logic [2:0] ST_DONE  = SWEEP_DONE;

  localparam logic [ADDR_SIZE-1:0] CNT_LAST = ADDR_SIZE'(DEPTH - 1);

  logic [2:0]           state_q, state_d;
  logic [ADDR_SIZE-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: if (start_i) begin
        state_d = ST_WRITE;
        cnt_d   = '0;
      end
      ST_WRITE: if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
`ifdef HPDCACHE_SRAM_SWEEP_CHECK_EN
        state_d = ST_READ;
`else
        state_d = ST_DONE;
`endif
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
`ifdef HPDCACHE_SRAM_SWEEP_CHECK_EN
      ST_READ: if (cnt_q == CNT_LAST) begin
        cnt_d   = '0;
        state_d = ST_DRAIN;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      ST_DRAIN: state_d = ST_DONE;
`endif
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy_o      = (state_q == ST_WRITE) || (state_q == ST_READ) || (state_q == ST_DRAIN);
  assign done_o      = (state_q == ST_DONE);
  assign req_ready_o = !busy_o;
  assign req_rdata_o = sram.sram_rdata;

  // While busy the functional request is simply dropped; the caller holds it until ready.
  always_comb begin
    sram.sram_cs    = req_cs_i;
    sram.sram_we    = req_we_i;
    sram.sram_addr  = req_addr_i;
    sram.sram_wdata = req_wdata_i;
    if (busy_o) begin
      sram.sram_cs    = (state_q != ST_DRAIN);
      sram.sram_we    = (state_q == ST_WRITE);
      sram.sram_addr  = cnt_q;
      sram.sram_wdata = INIT_VALUE;
    end
  end

`ifdef HPDCACHE_SRAM_SWEEP_CHECK_EN
  hpdcache_sram_sweep_checker #(
    .ADDR_SIZE (ADDR_SIZE),
    .DATA_SIZE (DATA_SIZE),
    .INIT_VALUE(INIT_VALUE)
  ) u_checker (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     ((state_q == ST_IDLE) && start_i),
    .rd_vld_i  (state_q == ST_READ),
    .rd_addr_i (cnt_q),
    .rdata_i   (sram.sram_rdata),
    .err_o     (err_o),
    .err_addr_o(err_addr_o)
  );
`else
  assign err_o      = 1'b0;
  assign err_addr_o = '0;
`endif
endmodule

// File: tb/tb_hpdcache_sram_sweep.sv
// Directed bench for hpdcache_sram_sweep: DEPTH=64 and DEPTH=48 instances with behavioural SRAMs.
module tb_hpdcache_sram_sweep;
  localparam int AW = 6;
  localparam int DW = 64;
`ifdef HPDCACHE_SRAM_SWEEP_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  localparam int DONE64 = CHK ? 2*64+2 : 64+1;
  localparam int DONE48 = CHK ? 2*48+2 : 48+1;

  int n_checks = 0;
  int n_pass   = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          a_rst_n, a_start, a_busy, a_done, a_err, a_ready;
  logic [AW-1:0] a_err_addr, a_req_addr;
  logic          a_req_cs, a_req_we;
  logic [DW-1:0] a_req_wdata, a_req_rdata;
  logic          b_rst_n, b_start, b_busy, b_done, b_err, b_ready;
  logic [AW-1:0] b_err_addr, b_req_addr;
  logic          b_req_cs, b_req_we;
  logic [DW-1:0] b_req_wdata, b_req_rdata;

  hpdcache_sram_sweep_if #(.ADDR_SIZE(AW), .DATA_SIZE(DW)) a_sram ();
  hpdcache_sram_sweep_if #(.ADDR_SIZE(AW), .DATA_SIZE(DW)) b_sram ();

  hpdcache_sram_sweep #(.ADDR_SIZE(AW), .DATA_SIZE(DW), .DEPTH(64)) dut64 (
    .clk(clk), .rst_n(a_rst_n), .start_i(a_start), .busy_o(a_busy), .done_o(a_done),
    .err_o(a_err), .err_addr_o(a_err_addr), .req_cs_i(a_req_cs), .req_we_i(a_req_we),
    .req_addr_i(a_req_addr), .req_wdata_i(a_req_wdata), .req_ready_o(a_ready),
    .req_rdata_o(a_req_rdata), .sram(a_sram)
  );

  hpdcache_sram_sweep #(.ADDR_SIZE(AW), .DATA_SIZE(DW), .DEPTH(48)) dut48 (
    .clk(clk), .rst_n(b_rst_n), .start_i(b_start), .busy_o(b_busy), .done_o(b_done),
    .err_o(b_err), .err_addr_o(b_err_addr), .req_cs_i(b_req_cs), .req_we_i(b_req_we),
    .req_addr_i(b_req_addr), .req_wdata_i(b_req_wdata), .req_ready_o(b_ready),
    .req_rdata_o(b_req_rdata), .sram(b_sram)
  );

  // Behavioural SRAMs; a_force makes addresses 17 and 40 read back as 1.
  logic [DW-1:0] a_mem [64];
  logic [DW-1:0] b_mem [64];
  logic          a_force;

  always @(posedge clk) begin
    if (a_sram.sram_cs) begin
      if (a_sram.sram_we) a_mem[a_sram.sram_addr] <= a_sram.sram_wdata;
      else if (a_force && (a_sram.sram_addr == 6'd17 || a_sram.sram_addr == 6'd40))
        a_sram.sram_rdata <= 64'd1;
      else a_sram.sram_rdata <= a_mem[a_sram.sram_addr];
    end
  end

  always @(posedge clk) begin
    if (b_sram.sram_cs) begin
      if (b_sram.sram_we) b_mem[b_sram.sram_addr] <= b_sram.sram_wdata;
      else b_sram.sram_rdata <= b_mem[b_sram.sram_addr];
    end
  end

  // Expected {cs, we, addr, busy, done, ready} for interval i after the start edge (req idle).
  function automatic logic [10:0] exp_vec(int i, int depth, int done_cyc);
    if (i >= 1 && i <= depth)                 return {2'b11, 6'(i-1), 3'b100};
    if (CHK && i > depth && i <= 2*depth)     return {2'b10, 6'(i-depth-1), 3'b100};
    if (CHK && i == 2*depth+1)                return {2'b00, 6'd0, 3'b100};
    if (i == done_cyc)                        return {2'b00, 6'd0, 3'b011};
    return {2'b00, 6'd0, 3'b001};
  endfunction

  task automatic test_reset();
    a_rst_n = 1'b0; b_rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if ({a_busy, a_done, a_err, a_err_addr, a_ready} !== {3'b000, 6'd0, 1'b1})
      $display("FAIL reset64 got=%b exp=%b", {a_busy, a_done, a_err, a_err_addr, a_ready}, {3'b000, 6'd0, 1'b1});
    else n_pass++;
    n_checks++;
    if ({b_busy, b_done, b_err, b_ready} !== 4'b0001)
      $display("FAIL reset48 got=%b exp=%b", {b_busy, b_done, b_err, b_ready}, 4'b0001);
    else n_pass++;
    @(negedge clk);
    a_rst_n = 1'b1; b_rst_n = 1'b1;
  endtask

  task automatic test_sweep();
    logic [10:0] act;
    int ndone = 0;
    @(negedge clk);
    a_start = 1'b1;
    #1;
    n_checks++;
    if ({a_busy, a_ready} !== 2'b01) $display("FAIL sweep_start_idle got=%b exp=01", {a_busy, a_ready});
    else n_pass++;
    for (int i = 1; i <= DONE64 + 2; i++) begin
      @(negedge clk);
      a_start = 1'b0;
      #1;
      act = {a_sram.sram_cs, a_sram.sram_we, (a_sram.sram_cs ? a_sram.sram_addr : 6'd0), a_busy, a_done, a_ready};
      if (a_done) ndone++;
      n_checks++;
      if (act !== exp_vec(i, 64, DONE64)) $display("FAIL sweep i=%0d got=%b exp=%b", i, act, exp_vec(i, 64, DONE64));
      else n_pass++;
      if (i <= 64) begin
        n_checks++;
        if (a_sram.sram_wdata !== 64'd0) $display("FAIL sweep_wdata i=%0d got=%h exp=0", i, a_sram.sram_wdata);
        else n_pass++;
      end
      if (i == DONE64) begin
        n_checks++;
        if (a_err !== 1'b0) $display("FAIL sweep_err got=%b exp=0", a_err);
        else n_pass++;
      end
    end
    n_checks++;
    if (ndone !== 1) $display("FAIL sweep_done_count got=%0d exp=1", ndone);
    else n_pass++;
  endtask

  task automatic test_errors();
    a_force = 1'b1;
    @(negedge clk);
    a_start = 1'b1;
    for (int i = 1; i <= DONE64; i++) begin
      @(negedge clk);
      a_start = 1'b0;
      #1;
      if (i == DONE64) begin
        n_checks++;
        if ({a_done, a_err, a_err_addr} !== (CHK ? {2'b11, 6'd17} : {2'b10, 6'd0}))
          $display("FAIL err_flag got=%b exp=%b", {a_done, a_err, a_err_addr}, (CHK ? {2'b11, 6'd17} : {2'b10, 6'd0}));
        else n_pass++;
      end
    end
    a_force = 1'b0;
    @(negedge clk);
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    #1;
    n_checks++;
    if ({a_err, a_err_addr} !== 7'd0) $display("FAIL err_clear got=%b exp=0", {a_err, a_err_addr});
    else n_pass++;
    for (int i = 2; i <= DONE64; i++) begin
      @(negedge clk);
      #1;
      if (i == DONE64) begin
        n_checks++;
        if ({a_done, a_err} !== 2'b10) $display("FAIL err_clean_sweep got=%b exp=10", {a_done, a_err});
        else n_pass++;
      end
    end
  endtask

  task automatic test_reset_mid();
    int ndone = 0;
    @(negedge clk);
    a_start = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      a_start = 1'b0;
      if (i == 20) a_rst_n = 1'b0;
      #1;
      if (i == 20) begin
        n_checks++;
        if ({a_busy, a_sram.sram_addr} !== {1'b1, 6'd19})
          $display("FAIL rstmid_pre got=%b exp=%b", {a_busy, a_sram.sram_addr}, {1'b1, 6'd19});
        else n_pass++;
      end
    end
    @(negedge clk);
    a_rst_n = 1'b1;
    a_req_cs = 1'b1; a_req_we = 1'b0; a_req_addr = 6'd9;
    #1;
    n_checks++;
    if ({a_busy, a_done, a_ready, a_sram.sram_cs, a_sram.sram_we, a_sram.sram_addr} !== {5'b00110, 6'd9})
      $display("FAIL rstmid_post got=%b exp=%b",
               {a_busy, a_done, a_ready, a_sram.sram_cs, a_sram.sram_we, a_sram.sram_addr}, {5'b00110, 6'd9});
    else n_pass++;
    @(negedge clk);
    a_req_cs = 1'b0;
    for (int i = 0; i < 80; i++) begin
      #1;
      if (a_done || a_busy) ndone++;
      @(negedge clk);
    end
    n_checks++;
    if (ndone !== 0) $display("FAIL rstmid_no_done got=%0d exp=0", ndone);
    else n_pass++;
  endtask

  task automatic test_passthrough_start();
    int leaks = 0;
    @(negedge clk);
    a_req_cs = 1'b1; a_req_we = 1'b1; a_req_addr = 6'd5; a_req_wdata = 64'hA5A5_0000_1234_5678;
    #1;
    n_checks++;
    if ({a_sram.sram_cs, a_sram.sram_we, a_sram.sram_addr, a_sram.sram_wdata, a_ready} !==
        {2'b11, 6'd5, 64'hA5A5_0000_1234_5678, 1'b1})
      $display("FAIL pt_write got=%h exp=%h", {a_sram.sram_cs, a_sram.sram_we, a_sram.sram_addr, a_sram.sram_wdata, a_ready},
               {2'b11, 6'd5, 64'hA5A5_0000_1234_5678, 1'b1});
    else n_pass++;
    @(negedge clk);
    a_req_we = 1'b0; a_start = 1'b1;
    #1;
    n_checks++;
    if ({a_sram.sram_cs, a_sram.sram_we, a_sram.sram_addr, a_busy, a_ready} !== {2'b10, 6'd5, 2'b01})
      $display("FAIL pt_read_start got=%b exp=%b", {a_sram.sram_cs, a_sram.sram_we, a_sram.sram_addr, a_busy, a_ready},
               {2'b10, 6'd5, 2'b01});
    else n_pass++;
    @(negedge clk);
    a_start = 1'b0;
    a_req_we = 1'b1; a_req_addr = 6'd33; a_req_wdata = 64'hFF;
    #1;
    n_checks++;
    if (a_req_rdata !== 64'hA5A5_0000_1234_5678) $display("FAIL pt_rdata got=%h exp=a5a5000012345678", a_req_rdata);
    else n_pass++;
    n_checks++;
    if ({a_sram.sram_cs, a_sram.sram_we, a_sram.sram_addr, a_sram.sram_wdata, a_busy, a_ready} !== {2'b11, 6'd0, 64'd0, 2'b10})
      $display("FAIL pt_first_write got=%h exp=%h", {a_sram.sram_cs, a_sram.sram_we, a_sram.sram_addr, a_sram.sram_wdata, a_busy, a_ready},
               {2'b11, 6'd0, 64'd0, 2'b10});
    else n_pass++;
    for (int i = 2; i <= DONE64; i++) begin
      @(negedge clk);
      #1;
      if (a_busy && (a_sram.sram_wdata === 64'hFF || (a_sram.sram_cs && a_sram.sram_addr === 6'd33 && a_sram.sram_we && i != 34)))
        leaks++;
      if (i == DONE64) begin
        n_checks++;
        if ({a_ready, a_sram.sram_cs, a_sram.sram_addr} !== {2'b11, 6'd33})
          $display("FAIL pt_resume got=%b exp=%b", {a_ready, a_sram.sram_cs, a_sram.sram_addr}, {2'b11, 6'd33});
        else n_pass++;
      end
    end
    n_checks++;
    if (leaks !== 0) $display("FAIL pt_blocked got=%0d exp=0", leaks);
    else n_pass++;
    @(negedge clk);
    a_req_cs = 1'b0; a_req_we = 1'b0;
  endtask

  task automatic test_depth48();
    logic [10:0] act;
    int ndone = 0;
    @(negedge clk);
    b_start = 1'b1;
    for (int i = 1; i <= DONE48 + 3; i++) begin
      @(negedge clk);
      b_start = (i == 10);
      #1;
      act = {b_sram.sram_cs, b_sram.sram_we, (b_sram.sram_cs ? b_sram.sram_addr : 6'd0), b_busy, b_done, b_ready};
      if (b_done) ndone++;
      n_checks++;
      if (act !== exp_vec(i, 48, DONE48)) $display("FAIL d48 i=%0d got=%b exp=%b", i, act, exp_vec(i, 48, DONE48));
      else n_pass++;
    end
    b_start = 1'b0;
    n_checks++;
    if (ndone !== 1) $display("FAIL d48_done_count got=%0d exp=1", ndone);
    else n_pass++;
  endtask

  initial begin
    a_rst_n = 1'b0; a_start = 1'b0; a_req_cs = 1'b0; a_req_we = 1'b0; a_req_addr = '0; a_req_wdata = '0;
    b_rst_n = 1'b0; b_start = 1'b0; b_req_cs = 1'b0; b_req_we = 1'b0; b_req_addr = '0; b_req_wdata = '0;
    a_force = 1'b0;
    test_reset();
    test_sweep();
    test_errors();
    test_reset_mid();
    test_passthrough_start();
    test_depth48();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
